// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit counter must represent 0..width without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B - bin), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bnext;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  full_subtractor u_cell (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_bnext)
  );

  assign w_last = (r_cnt == LAST_CNT);

  if (WIDTH == 1) begin : g_w1
    assign w_r_next = w_d;
  end else begin : g_wn
    assign w_r_next = {w_d, r_r_sr[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  // Result registers load on the last SHIFT edge so they are visible in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_r_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr <= minuend;
            r_b_sr <= subtrahend;
            r_brw  <= bin;
            r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= minuend[WIDTH-1];
            r_b_msb <= subtrahend[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_r_sr <= w_r_next;
          r_brw  <= w_bnext;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_r_next;
            r_bout <= w_bnext;
`ifdef SERIAL_SUB_OVF_EN
            // The final cell output is the result MSB.
            r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes minuend - subtrahend - bin one bit per clock, LSB first.
- Uses a single full-subtractor cell plus a borrow flip-flop. It is the inverse-arithmetic counterpart of the team's ripple full-adder datapath.
- Sits in the arithmetic library as an area-cheap subtract unit, driven by a start/done handshake from a controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- minuend  input  WIDTH  operand A; captured on accepted start.
- subtrahend  input  WIDTH  operand B; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  A - B - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out (1 = unsigned underflow).

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst, rst sampled on the rising edge of clk.
- Reset values: busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow flop and bit counter all clear; state=IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load A_sr<=minuend, B_sr<=subtrahend, brw<=bin, cnt<=0; go to SHIFT.
  - On start=0: hold.
- SHIFT, each cycle:
  - Cell inputs: a=A_sr[0], b=B_sr[0], br=brw.
  - d = a^b^br.
  - bnext = (~a&b) | (~(a^b)&br).
  - R_sr <= {d, R_sr[WIDTH-1:1]}. Shift A_sr and B_sr right by one. brw<=bnext. cnt<=cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- DONE:
  - diff<=R_sr, bout<=brw, done=1 for exactly this one cycle.
  - Next state is IDLE.
- Latency: start accepted at edge 0 -> done high in cycle WIDTH+1. diff/bout are valid from that cycle.
- diff/bout hold their value until the next DONE or rst. They do not change during a later SHIFT.
- start while busy=1, including in the DONE cycle, is ignored. Nothing queues, and no error is raised.
- Operand inputs are don't-care except on the accepting edge.
- rst mid-operation aborts immediately:
  - No done pulse.
  - Outputs return to reset values, including previously held diff/bout.
  - A start on the cycle after rst deasserts is accepted normally.
- WIDTH=1: one SHIFT cycle; done in cycle 2.
- Counter width: $clog2(WIDTH+1). Wrap never occurs because the count terminates at WIDTH-1.
- Arithmetic: unsigned modular. bout=1 exactly when {1'b0,A} < {1'b0,B} + bin.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output ovf (1 bit, reset 0), updated alongside diff in DONE.
  - ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), i.e. two's-complement signed overflow.
  - The operand MSBs are captured at start.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - State enum typedef sub_state_t {IDLE, SHIFT, DONE}.
  - Localparam function for counter width.
- One sub-module, full_subtractor (combinational: a, b, bin -> d, bout). Instantiated once in the datapath.
- The FSM, shift registers and counter live in the top.

Test Plan:
1. WIDTH=8: A=0x35, B=0x12, bin=0, start at cycle 0 -> done only in cycle 9; diff=0x23, bout=0; busy high cycles 1-9.
2. A=0x00, B=0x01, bin=0 -> diff=0xFF, bout=1. Then A=0x10, B=0x0F, bin=1 -> diff=0x00, bout=0.
3. A=0x80, B=0x01 -> diff=0x7F, bout=0; with SERIAL_SUB_OVF_EN, ovf=1. A=0x7F, B=0x01 -> ovf=0.
4. Start op A=0x55, B=0x11; pulse start with A=0xFF, B=0x00 at cycles 3 and 9 -> exactly one done; diff=0x44; second request ignored.
5. rst asserted at cycle 4 of an op -> next cycle busy=0, diff=0, bout=0, no done. Then A=0x09, B=0x03 -> diff=0x06 at cycle 9.
6. WIDTH=4 build: exhaustive A, B, bin (512 ops, back-to-back starts) vs reference model {bout,diff} = {1'b0,A} - B - bin; check WIDTH=1 latency of 2.
